// File: rtl/alu_pkg.sv
// Shared opcode definitions for the datapath ALU and its combinational decoder.
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD  = 3'b000;
  localparam opcode_t OP_SUB  = 3'b001;
  localparam opcode_t OP_MUL  = 3'b010;
  localparam opcode_t OP_M8Z  = 3'b011;
  localparam opcode_t OP_M14Z = 3'b100;
  localparam opcode_t OP_RSH2 = 3'b101;
  localparam opcode_t OP_ZERO = 3'b110;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: decodes the opcode and produces the next result and zero flag.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          ctrl,
  output logic [WIDTH-1:0] result_next,
  output logic             zero_next
);

  logic [WIDTH-1:0] m8z_val;
  logic [WIDTH-1:0] m14z_val;

  // Masks keep the low bits of b and clear everything above them.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      assign m8z_val[gi]  = (gi < 8) ? b[gi] : 1'b0;
      assign m14z_val[gi] = (gi < 2) ? b[gi] : 1'b0;
    end
  endgenerate

  always_comb begin
    result_next = '0;
    case (ctrl)
      OP_ADD:  result_next = a + b;
      OP_SUB:  result_next = a - b;
      OP_MUL:  result_next = a * b;
      OP_M8Z:  result_next = m8z_val;
      OP_M14Z: result_next = m14z_val;
      OP_RSH2: result_next = b >> 2;
      OP_ZERO: result_next = '0;
      default: result_next = '0;  // reserved and unknown opcodes yield zero
    endcase
  end

  assign zero_next = (result_next == '0);

endmodule

// File: rtl/alu.sv
// Datapath ALU top: registers the combinational result and zero flag with one-cycle latency.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ctrl,
  output logic [WIDTH-1:0] out,
  output logic             z
);

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] out_next;
  logic             z_reg;
  logic             z_next;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a          (a),
    .b          (b),
    .ctrl       (opcode_t'(ctrl)),
    .result_next(out_next),
    .zero_next  (z_next)
  );

  // z is registered from the same next-state result so it always tracks out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_reg <= '0;
      z_reg   <= 1'b1;
    end else begin
      out_reg <= out_next;
      z_reg   <= z_next;
    end
  end

  assign out = out_reg;
  assign z   = z_reg;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases from the test plan plus randomized ops vs a reference model.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  ctrl;
  logic [15:0] out;
  logic        z;

  int unsigned n_cmp;
  int unsigned n_err;

  alu #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .ctrl (ctrl),
    .out  (out),
    .z    (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model computed with plain integer arithmetic modulo 2^16.
  function automatic logic [15:0] ref_result(input logic [15:0] ra, input logic [15:0] rb,
                                             input logic [2:0] rc);
    longint unsigned x;
    longint unsigned y;
    x = longint'(ra);
    y = longint'(rb);
    case (rc)
      3'd0:    return 16'((x + y) % 65536);
      3'd1:    return 16'((x + 65536 - y) % 65536);
      3'd2:    return 16'((x * y) % 65536);
      3'd3:    return 16'(y % 256);
      3'd4:    return 16'(y % 4);
      3'd5:    return 16'(y / 4);
      default: return 16'd0;
    endcase
  endfunction

  task automatic drive(input logic [15:0] op_a, input logic [15:0] op_b,
                       input logic [2:0] op_c, input logic op_rst_n);
    a     = op_a;
    b     = op_b;
    ctrl  = op_c;
    rst_n = op_rst_n;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] exp_out, input logic exp_z);
    n_cmp++;
    assert (out === exp_out) else begin
      n_err++;
      $error("FAIL %s out=%h expected %h", tag, out, exp_out);
    end
    n_cmp++;
    assert (z === exp_z) else begin
      n_err++;
      $error("FAIL %s z=%b expected %b", tag, z, exp_z);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [2:0]  rc;
    logic        rr;
    logic [15:0] exp;
    n_cmp = 0;
    n_err = 0;
    a = '0; b = '0; ctrl = '0; rst_n = 1'b0;

    // Reset held for two edges with an ADD pending, then released.
    drive(16'd5, 16'd7, 3'd0, 1'b0);
    check("reset_edge1", 16'h0000, 1'b1);
    drive(16'd5, 16'd7, 3'd0, 1'b0);
    check("reset_edge2", 16'h0000, 1'b1);
    drive(16'd5, 16'd7, 3'd0, 1'b1);
    check("reset_release_add", 16'd12, 1'b0);
    $display("reset: release -> out=%0d z=%b", out, z);

    // Opcode sweep with a=22, b=10.
    drive(16'd22, 16'd10, 3'd0, 1'b1); check("sweep_add",  16'd32,  1'b0);
    drive(16'd22, 16'd10, 3'd1, 1'b1); check("sweep_sub",  16'd12,  1'b0);
    drive(16'd22, 16'd10, 3'd2, 1'b1); check("sweep_mul",  16'd220, 1'b0);
    drive(16'd22, 16'd10, 3'd3, 1'b1); check("sweep_m8z",  16'd10,  1'b0);
    drive(16'd22, 16'd10, 3'd4, 1'b1); check("sweep_m14z", 16'd2,   1'b0);
    drive(16'd22, 16'd10, 3'd5, 1'b1); check("sweep_rsh2", 16'd2,   1'b0);
    drive(16'd22, 16'd10, 3'd6, 1'b1); check("sweep_zero", 16'd0,   1'b1);
    $display("sweep: 7 opcodes issued with a=22 b=10");

    // Input changes between edges must not disturb the registered output.
    a = 16'd1; b = 16'd1; ctrl = 3'd0;
    #2;
    check("hold_between_edges", 16'd0, 1'b1);

    // Wrap-around cases.
    drive(16'hFFFF, 16'h0001, 3'd0, 1'b1); check("add_wrap", 16'h0000, 1'b1);
    drive(16'd3, 16'd5, 3'd1, 1'b1);       check("sub_wrap", 16'hFFFE, 1'b0);
    drive(16'd0, 16'd1, 3'd1, 1'b1);       check("sub_0_1",  16'hFFFF, 1'b0);
    drive(16'h0100, 16'h0100, 3'd2, 1'b1); check("mul_wrap", 16'h0000, 1'b1);
    drive(16'd300, 16'd300, 3'd2, 1'b1);   check("mul_300",  16'h5F90, 1'b0);

    // Masks and shift ignore operand A.
    drive(16'h0000, 16'hABCD, 3'd3, 1'b1); check("m8z_a0",   16'h00CD, 1'b0);
    drive(16'h0000, 16'hABCD, 3'd4, 1'b1); check("m14z_a0",  16'h0001, 1'b0);
    drive(16'h0000, 16'hABCD, 3'd5, 1'b1); check("rsh2_a0",  16'h2AF3, 1'b0);
    drive(16'hFFFF, 16'hABCD, 3'd3, 1'b1); check("m8z_aF",   16'h00CD, 1'b0);
    drive(16'hFFFF, 16'hABCD, 3'd4, 1'b1); check("m14z_aF",  16'h0001, 1'b0);
    drive(16'hFFFF, 16'hABCD, 3'd5, 1'b1); check("rsh2_aF",  16'h2AF3, 1'b0);

    // Reserved opcode.
    drive(16'd9, 16'd9, 3'd7, 1'b1); check("reserved", 16'h0000, 1'b1);

    // Reset mid-stream after back-to-back ADD and MUL.
    drive(16'd4, 16'd6, 3'd0, 1'b1); check("mid_add", 16'd10, 1'b0);
    drive(16'd4, 16'd6, 3'd2, 1'b1); check("mid_mul", 16'd24, 1'b0);
    drive(16'd4, 16'd6, 3'd2, 1'b0); check("mid_reset", 16'h0000, 1'b1);
    drive(16'd4, 16'd6, 3'd0, 1'b0); check("mid_reset_hold", 16'h0000, 1'b1);
    drive(16'd1, 16'd2, 3'd0, 1'b1); check("mid_release", 16'd3, 1'b0);
    $display("midstream reset: out=%0d z=%b after release", out, z);

    // Randomized operations with occasional resets and zero operands.
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 3'($urandom_range(0, 7));
      rr = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) ra = 16'h0000;
      if ($urandom_range(0, 9) == 0) rb = 16'h0000;
      exp = rr ? ref_result(ra, rb, rc) : 16'h0000;
      drive(ra, rb, rc, rr);
      check($sformatf("rand%0d", i), exp, (exp == 16'h0000));
      $display("rand%0d: rst_n=%b ctrl=%0d a=%h b=%h -> out=%h z=%b", i, rr, rc, ra, rb, out, z);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
